ifid_instr_buffer: RTL and testbench

//  IF->ID boundary of the 5-stage MIPS pipeline. A 2-entry instruction queue

---
 rtl/ifid_instr_buffer_pkg.sv | 25 ++
 rtl/ifid_queue_mem.sv | 35 +++
 rtl/ifid_instr_buffer.sv | 106 ++++++++++
 tb/tb_ifid_instr_buffer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifid_instr_buffer_pkg.sv
// Shared types and constants for the IF->ID instruction buffer.
`default_nettype none

package ifid_instr_buffer_pkg;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [4:0]  EXC_ADEL = 5'd4;

  typedef struct packed {
    logic        exc;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_entry_t;

  // AdEL on fetch: misaligned or outside the instruction memory window.
  function automatic logic pc_fault(input logic [31:0] pc,
                                    input logic [31:0] lo,
                                    input logic [31:0] hi);
    return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_queue_mem.sv
// DEPTH x 65-bit entry storage: one synchronous write port, one async read port.
`default_nettype none

module ifid_queue_mem
  import ifid_instr_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifid_entry_t   wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifid_entry_t   rdata_o
);

  ifid_entry_t mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ifid_instr_buffer.sv
// IF->ID pipeline boundary: 2-entry instruction queue with flush and AdEL tagging.
`default_nettype none

module ifid_instr_buffer
  import ifid_instr_buffer_pkg::*;
#(
  parameter int          DEPTH = 2,
  parameter logic [31:0] PC_LO = PC_RESET,
  parameter logic [31:0] PC_HI = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        in_ready,
  input  logic        flush,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc8,
  output logic        out_exc,
  output logic [4:0]  out_exccode
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;
  cnt_t count_q,  count_d;

  logic        push;
  logic        pop;
  logic        in_fault;
  ifid_entry_t wr_entry;
  ifid_entry_t head;

  assign in_ready  = (count_q != CNT_FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  // A faulted fetch keeps its pc for EPC but never hands a word to decode.
  assign in_fault       = pc_fault(in_pc, PC_LO, PC_HI);
  assign wr_entry.exc   = in_fault;
  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_fault ? NOP : in_instr;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + cnt_t'(1);
        2'b01:   count_d = count_q - cnt_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ifid_queue_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .reset   (reset),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

  assign out_instr   = out_valid ? head.instr : NOP;
  assign out_pc      = out_valid ? head.pc : 32'h0;
  assign out_pc8     = out_valid ? (head.pc + 32'd8) : 32'h0;
  assign out_exc     = out_valid & head.exc;
  assign out_exccode = out_exc ? EXC_ADEL : 5'd0;

endmodule

`default_nettype wire

// File: tb/tb_ifid_instr_buffer.sv
// Scoreboard bench for ifid_instr_buffer: driver queues expected words, monitor checks pops.
`default_nettype none

module tb_ifid_instr_buffer;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        exc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_ready;
  logic        flush;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic        out_exc;
  logic [4:0]  out_exccode;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ifid_instr_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_pc8     (out_pc8),
    .out_exc     (out_exc),
    .out_exccode (out_exccode)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < 32'h0000_3000) || (pc > 32'h0000_6FFC);
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.exc   = exp_fault(pc);
    e.pc    = pc;
    e.instr = e.exc ? 32'h0 : instr;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the word on the fetch port until accepted (bounded), then drops in_valid.
  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bit done = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready && !flush) begin
        sb.push_back(mk_exp(instr, pc));
        done = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("offer_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain_left", sb.size(), 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  // Monitor: a head presented with out_ready high is consumed at the next edge.
  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", out_instr, 32'hDEAD_BEEF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_instr", out_instr, e.instr);
        chk("mon_pc", out_pc, e.pc);
        chk("mon_pc8", out_pc8, e.pc + 32'd8);
        chk("mon_exc", {31'd0, out_exc}, {31'd0, e.exc});
        chk("mon_exccode", {27'd0, out_exccode}, e.exc ? 32'd4 : 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc8", out_pc8, 32'h0);
    reset = 1'b0;
    tick();

    // Single push into empty queue: visible one edge later.
    in_valid = 1'b1; in_instr = 32'h2408_0001; in_pc = 32'h0000_3000;
    sb.push_back(mk_exp(32'h2408_0001, 32'h0000_3000));
    tick();
    in_valid = 1'b0;
    chk("t2_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_instr", out_instr, 32'h2408_0001);
    chk("t2_pc8", out_pc8, 32'h0000_3008);
    tick();
    chk("t2_empty_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_empty_pc", out_pc, 32'h0);

    // Stall: fill to full, third word blocked until space opens.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h1111_0001; in_pc = 32'h0000_3010;
    chk("t3_ready0", {31'd0, in_ready}, 32'd1);
    sb.push_back(mk_exp(32'h1111_0001, 32'h0000_3010));
    tick();
    in_instr = 32'h1111_0002; in_pc = 32'h0000_3014;
    chk("t3_ready1", {31'd0, in_ready}, 32'd1);
    sb.push_back(mk_exp(32'h1111_0002, 32'h0000_3014));
    tick();
    in_instr = 32'h1111_0003; in_pc = 32'h0000_3018;
    chk("t3_full", {31'd0, in_ready}, 32'd0);
    chk("t3_head", out_instr, 32'h1111_0001);
    tick();
    chk("t3_full_hold", {31'd0, in_ready}, 32'd0);
    chk("t3_head_hold", out_instr, 32'h1111_0001);
    out_ready = 1'b1;
    offer(32'h1111_0003, 32'h0000_3018);
    drain();

    // Flush with a simultaneous push while full.
    out_ready = 1'b0;
    offer(32'h2222_0001, 32'h0000_3100);
    offer(32'h2222_0002, 32'h0000_3104);
    chk("t4_full", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_instr = 32'h2222_0003; in_pc = 32'h0000_3108; flush = 1'b1;
    sb.delete();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("t4_no_ghost", {31'd0, out_valid}, 32'd0);

    // Fetch-address exceptions and window boundaries.
    out_ready = 1'b0;
    offer(32'h1234_5678, 32'h0000_3002);
    offer(32'hAAAA_BBBB, 32'h0000_7000);
    chk("t5_exc", {31'd0, out_exc}, 32'd1);
    chk("t5_code", {27'd0, out_exccode}, 32'd4);
    chk("t5_instr", out_instr, 32'h0);
    chk("t5_pc", out_pc, 32'h0000_3002);
    out_ready = 1'b1;
    tick();
    chk("t5b_exc", {31'd0, out_exc}, 32'd1);
    chk("t5b_code", {27'd0, out_exccode}, 32'd4);
    chk("t5b_instr", out_instr, 32'h0);
    chk("t5b_pc", out_pc, 32'h0000_7000);
    tick();
    out_ready = 1'b0;
    offer(32'h3333_0001, 32'hFFFF_FFFC);
    chk("t5_pc8_wrap", out_pc8, 32'h0000_0004);
    chk("t5_wrap_exc", {31'd0, out_exc}, 32'd1);
    out_ready = 1'b1;
    offer(32'h3333_0002, 32'h0000_6FFC);
    offer(32'h3333_0003, 32'h0000_2FFC);
    offer(32'h3333_0004, 32'h0000_3000);
    drain();

    // Steady push&pop at count=1; pointers wrap repeatedly.
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h4400_0000; in_pc = 32'h0000_4000;
    sb.push_back(mk_exp(32'h4400_0000, 32'h0000_4000));
    tick();
    for (int i = 1; i <= 10; i++) begin
      in_instr = 32'h4400_0000 + i;
      in_pc    = 32'h0000_4000 + 32'(i * 4);
      chk("t6_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_delay", out_instr, 32'h4400_0000 + 32'(i - 1));
      sb.push_back(mk_exp(in_instr, in_pc));
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-stream with the queue full.
    out_ready = 1'b0;
    offer(32'h5555_0001, 32'h0000_3200);
    offer(32'h5555_0002, 32'h0000_3204);
    #2;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("t1_valid", {31'd0, out_valid}, 32'd0);
    chk("t1_instr", out_instr, 32'h0);
    chk("t1_ready", {31'd0, in_ready}, 32'd1);
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    offer(32'h5555_0003, 32'h0000_3300);
    chk("t1_first", out_instr, 32'h5555_0003);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
